// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key inputs and conditioned level/pulse outputs
interface key_conditioner_if;
  logic [2:0] key_raw;
  logic [2:0] key_level;
  logic       pre_pulse;
  logic       next_pulse;
  logic       confirm_pulse;

  modport master (output key_raw, input key_level, pre_pulse, next_pulse, confirm_pulse);
  modport slave  (input key_raw, output key_level, pre_pulse, next_pulse, confirm_pulse);
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-key sync/debounce, press pulses; KEY_AUTOREPEAT_EN adds pre/next auto-repeat
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  key_conditioner_if.slave bus
);
  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
  localparam int              HD_W    = $clog2(REPEAT_DELAY + 1);
  localparam int              RR_W    = $clog2(REPEAT_RATE + 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(REPEAT_DELAY - 1);
  localparam logic [RR_W-1:0] RR_LAST = RR_W'(REPEAT_RATE - 1);
  logic [HD_W-1:0] r_hold [2];
  logic [RR_W-1:0] r_rate [2];
  logic [1:0]      w_rep;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif

  logic [2:0]      r_sync1, r_sync2, r_level, r_pulse;
  logic [DB_W-1:0] r_db_cnt [3];
  state_t          r_state [3];
  logic [2:0]      w_toggle, w_rise, w_fall, w_fire;

  always_comb begin
    w_toggle = '0;
    w_rise   = '0;
    w_fall   = '0;
    for (int i = 0; i < 3; i++) begin
      w_toggle[i] = (r_sync2[i] != r_level[i]) && (r_db_cnt[i] == DB_LAST);
      w_rise[i]   = w_toggle[i] & ~r_level[i];
      w_fall[i]   = w_toggle[i] & r_level[i];
    end
`ifdef KEY_AUTOREPEAT_EN
    w_rep = '0;
    for (int i = 0; i < 2; i++)
      w_rep[i] = !w_fall[i] && ((r_state[i] == HELD && r_hold[i] == HD_LAST) ||
                                (r_state[i] == REPEAT && r_rate[i] == RR_LAST));
    w_fire = w_rise | {1'b0, w_rep};
`else
    w_fire = w_rise;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_pulse <= '0;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
        r_state[i]  <= IDLE;
      end
`ifdef KEY_AUTOREPEAT_EN
      for (int i = 0; i < 2; i++) begin
        r_hold[i] <= '0;
        r_rate[i] <= '0;
      end
`endif
    end else begin
      r_sync1 <= bus.key_raw;
      r_sync2 <= r_sync1;
      r_level <= r_level ^ w_toggle;
      // Simultaneous pre and next cancel each other; confirm is never masked.
      r_pulse <= {w_fire[2], w_fire[1] & ~w_fire[0], w_fire[0] & ~w_fire[1]};
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i] || w_toggle[i])
          r_db_cnt[i] <= '0;
        else
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        if (w_fall[i])
          r_state[i] <= IDLE;
        else if (w_rise[i])
          r_state[i] <= HELD;
      end
`ifdef KEY_AUTOREPEAT_EN
      for (int i = 0; i < 2; i++) begin
        if (w_fall[i] || r_state[i] == IDLE) begin
          r_hold[i] <= '0;
          r_rate[i] <= '0;
        end else if (r_state[i] == HELD) begin
          if (r_hold[i] == HD_LAST)
            r_state[i] <= REPEAT;
          else
            r_hold[i] <= r_hold[i] + HD_W'(1);
        end else begin
          r_rate[i] <= (r_rate[i] == RR_LAST) ? '0 : r_rate[i] + RR_W'(1);
        end
      end
`endif
    end
  end

  assign bus.key_level     = r_level;
  assign bus.pre_pulse     = r_pulse[0];
  assign bus.next_pulse    = r_pulse[1];
  assign bus.confirm_pulse = r_pulse[2];
endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed and random key stimulus against a behavioural key model
`timescale 1ns/1ps
module tb_key_conditioner;
  localparam int DB = 4, RD = 20, RR = 8;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  key_conditioner_if bus();

  key_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;

  // Model: raw samples per edge, level flips after DB consecutive differing synced samples.
  logic [2:0] hist[$];
  bit         m_level[3];
  int         m_run[3];
  int         m_rise[3];
  logic [5:0] m_exp;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) begin
      m_level[i] = 1'b0;
      m_run[i]   = 0;
      m_rise[i]  = -1;
    end
    m_exp = '0;
  endfunction

  function automatic void model_edge(input logic [2:0] s);
    bit         fire[3];
    logic [2:0] d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(s);
    d = (hist.size() >= 3) ? hist[hist.size()-3] : 3'b000;
    if (hist.size() > 3) void'(hist.pop_front());
    for (int i = 0; i < 3; i++) begin
      if (d[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_level[i] = !m_level[i];
          m_run[i]   = 0;
          if (m_level[i]) m_rise[i] = cyc;
        end
      end else begin
        m_run[i] = 0;
      end
      fire[i] = m_level[i] && ((cyc == m_rise[i]) ||
                (AUTO && i < 2 && (cyc - m_rise[i]) >= RD && ((cyc - m_rise[i] - RD) % RR) == 0));
    end
    m_exp = {m_level[2], m_level[1], m_level[0], fire[2], fire[1] && !fire[0], fire[0] && !fire[1]};
  endfunction

  function automatic logic [5:0] observed();
    return {bus.key_level, bus.confirm_pulse, bus.next_pulse, bus.pre_pulse};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(bus.key_raw);
    #1;
  endtask

  task automatic test_reset();
    bus.key_raw = 3'b000;
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (observed() !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%b want=000000", cyc, observed());
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
    end
  endtask

  task automatic test_press_release();
    int base, first, npulse, fall;
    base = cyc + 1; first = -1; npulse = 0; fall = -1;
    bus.key_raw = 3'b001;
    for (int k = 0; k < 30; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL press cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.pre_pulse) begin npulse++; if (first < 0) first = cyc - base; end
    end
    vectors++;
    if (first !== 5 || (!AUTO && npulse !== 1)) begin
      miscompares++;
      $display("FAIL press_pulse first_edge=%0d count=%0d want edge 5", first, npulse);
    end
    base = cyc + 1; npulse = 0;
    bus.key_raw = 3'b000;
    for (int k = 0; k < 12; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL release cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.pre_pulse) npulse++;
      if (!bus.key_level[0] && fall < 0) fall = cyc - base;
    end
    vectors++;
    if (npulse !== 0 || fall !== DB + 1) begin
      miscompares++;
      $display("FAIL release_edge pulses=%0d fall_edge=%0d want 0 and %0d", npulse, fall, DB + 1);
    end
  endtask

  task automatic test_glitch();
    int npulse;
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      bus.key_raw = ((k % 4) < 3) ? 3'b010 : 3'b000;
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.next_pulse || bus.key_level[1]) npulse++;
    end
    vectors++;
    if (npulse !== 0) begin
      miscompares++;
      $display("FAIL glitch_quiet got=%0d level/pulse cycles want=0", npulse);
    end
    bus.key_raw = 3'b000;
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_simultaneous();
    int npn, ncf;
    npn = 0; ncf = 0;
    bus.key_raw = 3'b011;
    for (int k = 0; k < 15; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL simul cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.pre_pulse || bus.next_pulse) npn++;
    end
    vectors++;
    if (bus.key_level !== 3'b011) begin
      miscompares++;
      $display("FAIL simul_level got=%b want=011", bus.key_level);
    end
    bus.key_raw = 3'b111;
    for (int k = 0; k < 15; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL simul_confirm cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.pre_pulse || bus.next_pulse) npn++;
      if (bus.confirm_pulse) ncf++;
    end
    vectors++;
    if (npn !== 0 || ncf !== 1) begin
      miscompares++;
      $display("FAIL simul_count pre_next=%0d confirm=%0d want 0 and 1", npn, ncf);
    end
    bus.key_raw = 3'b000;
    for (int k = 0; k < 10; k++) step();
  endtask

  task automatic test_hold();
    int base, ncf;
    int got[$];
    int want[$];
    base = cyc + 1; ncf = 0;
    if (AUTO) want = '{5, 25, 33, 41, 49, 57};
    else      want = '{5};
    bus.key_raw = 3'b001;
    for (int k = 0; k < 60; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL hold cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.pre_pulse) got.push_back(cyc - base);
    end
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL hold_edges got=%p want=%p", got, want);
    end
    bus.key_raw = 3'b000;
    for (int k = 0; k < 10; k++) step();
    bus.key_raw = 3'b100;
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.confirm_pulse) ncf++;
    end
    vectors++;
    if (ncf !== 1) begin
      miscompares++;
      $display("FAIL hold_confirm got=%0d pulses want=1", ncf);
    end
    bus.key_raw = 3'b000;
    for (int k = 0; k < 10; k++) step();
  endtask

  task automatic test_reset_mid_press();
    int base;
    int got[$];
    base = cyc + 1;
    bus.key_raw = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.pre_pulse) got.push_back(cyc - base);
    end
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (observed() !== 6'b000000) begin
        miscompares++;
        $display("FAIL midreset cyc=%0d got=%b want=000000", cyc, observed());
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL midreset_after cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.pre_pulse) got.push_back(cyc - base);
    end
    vectors++;
    if (got.size() != 1 || got[0] != 12) begin
      miscompares++;
      $display("FAIL midreset_edge got=%p want='{12}", got);
    end
    bus.key_raw = 3'b000;
    for (int k = 0; k < 10; k++) step();
  endtask

  task automatic test_saturation();
    int ncf;
    ncf = 0;
    bus.key_raw = 3'b100;
    for (int k = 0; k < 1000; k++) begin
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL saturate cyc=%0d got=%b want=%b", cyc, observed(), m_exp);
      end
      if (bus.confirm_pulse) ncf++;
    end
    vectors++;
    if (ncf !== 1) begin
      miscompares++;
      $display("FAIL saturate_count got=%0d want=1", ncf);
    end
    bus.key_raw = 3'b000;
    for (int k = 0; k < 10; k++) step();
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int k = 0; k < 3000; k++) begin
      if (left == 0) begin
        bus.key_raw = 3'($urandom_range(0, 7));
        left = $urandom_range(1, 40);
        if ($urandom_range(0, 60) == 0) begin
          rst_n = 1'b0;
          model_reset();
        end
      end else if (!rst_n && $urandom_range(0, 2) == 0) begin
        rst_n = 1'b1;
      end
      left--;
      step();
      vectors++;
      if (observed() !== m_exp) begin
        miscompares++;
        $display("FAIL random cyc=%0d raw=%b got=%b want=%b", cyc, bus.key_raw, observed(), m_exp);
      end
    end
    rst_n = 1'b1;
    bus.key_raw = 3'b000;
    for (int k = 0; k < 10; k++) step();
  endtask

  initial begin
    bus.key_raw = 3'b000;
    test_reset();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_hold();
    test_reset_mid_press();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
